mips_mc_ctrl: RTL and testbench

Multicycle control unit for the team's MIPS subset: ADD, SUB, SLT, ADDI, SLTI, LW, SW, BEQ, BNE. It sequences a shared-ALU, single-port-memory datapath through fetch/decode/execute/memory/writeback. It also generates every mux select and write strobe that datapath needs, and stalls on a memory ready handshake. It sits beside the multicycle datapath (PC, IR, MDR, A/B, ALUOut, rf, alu) in place of per-instruction combinational decode.

---
 rtl/mips_pkg.sv | 117 +++++++++++
 rtl/mips_mc_ctrl_if.sv | 36 +++
 rtl/mips_mc_decode.sv | 41 ++++
 rtl/mips_mc_ctrl.sv | 91 +++++++++
 tb/tb_mips_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS subset: opcodes, functs, datapath selects,
// control-unit states and the Moore output decode of the multicycle controller.
package mips_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'd0;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'd1;

  localparam logic [SEL_W-1:0] SRCB_B       = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_4       = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [SEL_W-1:0] WB_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] WB_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] WB_SLT    = 2'd2;

  typedef enum logic [ST_W-1:0] {
    RST      = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    WB_R     = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WR   = 4'd9,
    WB_LW    = 4'd10,
    TRAP     = 4'd11,
    BRANCH   = 4'd12
  } state_e;

  // Arithmetic (variant 1 = sub), set-less-than, load/store (1 = store), branch (1 = bne)
  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_SLT   = 2'd1,
    CLS_MEM   = 2'd2,
    CLS_BR    = 2'd3
  } cls_e;

  typedef struct packed {
    logic             mem_req;
    logic             mem_wr;
    logic             iord;
    logic             pc_src;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_sel;
    logic             rf_wr;
    logic             reg_dst;
    logic [SEL_W-1:0] wb_sel;
    logic             trap;
  } ctrl_t;

  // Pure state-driven strobes; handshake-qualified strobes live in the controller.
  function automatic ctrl_t moore_out(state_e s, cls_e c, logic v);
    ctrl_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.mem_req   = 1'b1;
        o.alu_src_b = SRCB_4;
      end
      DECODE: o.alu_src_b = SRCB_IMM_SH2;
      EXEC_R, EXEC_I: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = (s == EXEC_R) ? SRCB_B : SRCB_IMM;
        o.alu_sel   = (c == CLS_SLT || v) ? ALU_SUB : ALU_ADD;
      end
      WB_R, WB_I: begin
        o.rf_wr   = 1'b1;
        o.reg_dst = (s == WB_R);
        o.wb_sel  = (c == CLS_SLT) ? WB_SLT : WB_ALUOUT;
      end
      MEM_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_IMM;
      end
      MEM_RD, MEM_WR: begin
        o.mem_req = 1'b1;
        o.mem_wr  = (s == MEM_WR);
        o.iord    = 1'b1;
      end
      WB_LW: begin
        o.rf_wr  = 1'b1;
        o.wb_sel = WB_MDR;
      end
      BRANCH: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_B;
        o.alu_sel   = ALU_SUB;
        o.pc_src    = 1'b1;
      end
      TRAP:    o.trap = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface mips_mc_ctrl_if;
  import mips_pkg::*;

  logic [OP_W-1:0]  opcode;
  logic [FN_W-1:0]  funct;
  logic             alu_z;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_wr;
  logic             iord;
  logic             ir_wr;
  logic             mdr_wr;
  logic             pc_wr;
  logic             pc_src;
  logic             alu_src_a;
  logic [SEL_W-1:0] alu_src_b;
  logic [SEL_W-1:0] alu_sel;
  logic             rf_wr;
  logic             reg_dst;
  logic [SEL_W-1:0] wb_sel;
  logic             trap;
  logic [ST_W-1:0]  state;

  modport master (
    input  opcode, funct, alu_z, mem_ready,
    output mem_req, mem_wr, iord, ir_wr, mdr_wr, pc_wr, pc_src, alu_src_a,
           alu_src_b, alu_sel, rf_wr, reg_dst, wb_sel, trap, state
  );

  modport slave (
    output opcode, funct, alu_z, mem_ready,
    input  mem_req, mem_wr, iord, ir_wr, mdr_wr, pc_wr, pc_src, alu_src_a,
           alu_src_b, alu_sel, rf_wr, reg_dst, wb_sel, trap, state
  );
endinterface

// File: rtl/mips_mc_decode.sv
// Opcode/funct to instruction class, variant and illegal flag.
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  output cls_e            cls,
  output logic            variant,
  output logic            illegal
);

  always_comb begin
    cls     = CLS_ARITH;
    variant = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls = CLS_ARITH;
          FN_SUB:  variant = 1'b1;
          FN_SLT:  cls = CLS_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: cls = CLS_ARITH;
      OP_SLTI: cls = CLS_SLT;
      OP_LW:   cls = CLS_MEM;
      OP_SW: begin
        cls     = CLS_MEM;
        variant = 1'b1;
      end
      OP_BEQ: cls = CLS_BR;
      OP_BNE: begin
        cls     = CLS_BR;
        variant = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath select and strobe, stalling on the memory handshake.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mips_mc_ctrl_if.master bus
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d, cls_dec;
  logic   var_q, var_d, var_dec, illegal;
  ctrl_t  out_q;

  mips_mc_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .cls     (cls_dec),
    .variant (var_dec),
    .illegal (illegal)
  );

  function automatic state_e next_state(state_e s, logic vq, cls_e cd, logic ill,
                                        logic rtype, logic rdy);
    state_e n;
    n = s;
    case (s)
      RST:    n = FETCH;
      FETCH:  if (rdy) n = DECODE;
      DECODE: begin
        if (ill)                   n = TRAP;
        else if (cd == CLS_MEM)    n = MEM_ADDR;
        else if (cd == CLS_BR)     n = BRANCH;
        else if (rtype)            n = EXEC_R;
        else                       n = EXEC_I;
      end
      EXEC_R:   n = WB_R;
      EXEC_I:   n = WB_I;
      MEM_ADDR: begin
        if (vq) n = MEM_WR;
        else    n = MEM_RD;
      end
      MEM_RD:   if (rdy) n = WB_LW;
      MEM_WR:   if (rdy) n = FETCH;
      WB_R, WB_I, WB_LW, BRANCH: n = FETCH;
      default:  n = TRAP;
    endcase
    return n;
  endfunction

  // Class/variant are captured once in DECODE so later states ignore the live IR
  assign cls_d   = (state_q == DECODE) ? cls_dec : cls_q;
  assign var_d   = (state_q == DECODE) ? var_dec : var_q;
  assign state_d = next_state(state_q, var_q, cls_dec, illegal,
                              bus.opcode == OP_RTYPE, bus.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      cls_q   <= CLS_ARITH;
      var_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      var_q   <= var_d;
      out_q   <= moore_out(state_d, cls_d, var_d);
    end
  end

  assign bus.mem_req   = out_q.mem_req;
  assign bus.mem_wr    = out_q.mem_wr;
  assign bus.iord      = out_q.iord;
  assign bus.pc_src    = out_q.pc_src;
  assign bus.alu_src_a = out_q.alu_src_a;
  assign bus.alu_src_b = out_q.alu_src_b;
  assign bus.alu_sel   = out_q.alu_sel;
  assign bus.rf_wr     = out_q.rf_wr;
  assign bus.reg_dst   = out_q.reg_dst;
  assign bus.wb_sel    = out_q.wb_sel;
  assign bus.trap      = out_q.trap;
  assign bus.state     = state_q;

  // Strobes qualified by the current-cycle handshake or ALU zero flag
  assign bus.ir_wr  = (state_q == FETCH) && bus.mem_ready;
  assign bus.mdr_wr = (state_q == MEM_RD) && bus.mem_ready;
  assign bus.pc_wr  = ((state_q == FETCH) && bus.mem_ready) ||
                      ((state_q == BRANCH) && (bus.alu_z ^ var_q));

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized cycle-by-cycle check of mips_mc_ctrl against an instruction-level model.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] o;
    logic        rdy;
    logic        z;
    bit          scr;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [16:0] ov(input logic req, wr, iord, irw, mdrw, pcw, pcs,
                                     srca, input logic [1:0] srcb, sel,
                                     input logic rf, dst, input logic [1:0] wb,
                                     input logic trp);
    return {req, wr, iord, irw, mdrw, pcw, pcs, srca, srcb, sel, rf, dst, wb, trp};
  endfunction

  function automatic logic [16:0] dut_o();
    return {bus.mem_req, bus.mem_wr, bus.iord, bus.ir_wr, bus.mdr_wr, bus.pc_wr,
            bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.rf_wr,
            bus.reg_dst, bus.wb_sel, bus.trap};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit legal(input logic [5:0] op, fn);
    case (op)
      OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
      OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic [16:0] o, input logic rdy,
                      input logic z, input bit scr);
    q.push_back('{st: st, o: o, rdy: rdy, z: z, scr: scr});
  endtask

  // Expected cycle list of one instruction, straight from the per-instruction rules
  task automatic build(input logic [5:0] op, fn, input int fw, mw, ntrap, zf);
    logic sub, slt, lw, z, pcw;
    q.delete();
    for (int i = 0; i < fw; i++)
      push(FETCH, ov(1,0,0,0,0,0,0,0,SRCB_4,ALU_ADD,0,0,WB_ALUOUT,0), 1'b0, rb(), 1'b0);
    push(FETCH, ov(1,0,0,1,0,1,0,0,SRCB_4,ALU_ADD,0,0,WB_ALUOUT,0), 1'b1, rb(), 1'b0);
    push(DECODE, ov(0,0,0,0,0,0,0,0,SRCB_IMM_SH2,ALU_ADD,0,0,WB_ALUOUT,0), rb(), rb(), 1'b0);
    if (!legal(op, fn)) begin
      for (int i = 0; i < ntrap; i++)
        push(TRAP, ov(0,0,0,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,1), rb(), rb(), 1'b1);
    end else if (op == OP_RTYPE || op == OP_ADDI || op == OP_SLTI) begin
      slt = (op == OP_SLTI) || (op == OP_RTYPE && fn == FN_SLT);
      sub = slt || (op == OP_RTYPE && fn == FN_SUB);
      if (op == OP_RTYPE) begin
        push(EXEC_R, ov(0,0,0,0,0,0,0,1,SRCB_B,sub ? ALU_SUB : ALU_ADD,0,0,WB_ALUOUT,0),
             rb(), rb(), 1'b1);
        push(WB_R, ov(0,0,0,0,0,0,0,0,2'd0,2'd0,1,1,slt ? WB_SLT : WB_ALUOUT,0),
             rb(), rb(), 1'b1);
      end else begin
        push(EXEC_I, ov(0,0,0,0,0,0,0,1,SRCB_IMM,sub ? ALU_SUB : ALU_ADD,0,0,WB_ALUOUT,0),
             rb(), rb(), 1'b1);
        push(WB_I, ov(0,0,0,0,0,0,0,0,2'd0,2'd0,1,0,slt ? WB_SLT : WB_ALUOUT,0),
             rb(), rb(), 1'b1);
      end
    end else if (op == OP_LW || op == OP_SW) begin
      lw = (op == OP_LW);
      push(MEM_ADDR, ov(0,0,0,0,0,0,0,1,SRCB_IMM,ALU_ADD,0,0,WB_ALUOUT,0), rb(), rb(), 1'b1);
      for (int i = 0; i < mw; i++)
        push(lw ? MEM_RD : MEM_WR, ov(1,!lw,1,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,0),
             1'b0, rb(), 1'b1);
      push(lw ? MEM_RD : MEM_WR, ov(1,!lw,1,0,lw,0,0,0,2'd0,2'd0,0,0,2'd0,0),
           1'b1, rb(), 1'b1);
      if (lw)
        push(WB_LW, ov(0,0,0,0,0,0,0,0,2'd0,2'd0,1,0,WB_MDR,0), rb(), rb(), 1'b1);
    end else begin
      z   = (zf < 0) ? rb() : zf[0];
      pcw = (op == OP_BEQ) ? z : !z;
      push(BRANCH, ov(0,0,0,0,0,pcw,1,1,SRCB_B,ALU_SUB,0,0,WB_ALUOUT,0), rb(), z, 1'b1);
    end
  endtask

  // Drive and check one instruction; entered and left 1ns after a rising edge
  task automatic exec_instr(input string name, input logic [5:0] op, fn,
                            input int fw, mw, ntrap, zf, max_cyc);
    int n;
    build(op, fn, fw, mw, ntrap, zf);
    n = q.size();
    if (max_cyc >= 0 && max_cyc < n) n = max_cyc;
    for (int i = 0; i < n; i++) begin
      bus.opcode    = q[i].scr ? 6'($urandom) : op;
      bus.funct     = q[i].scr ? 6'($urandom) : fn;
      bus.mem_ready = q[i].rdy;
      bus.alu_z     = q[i].z;
      @(negedge clk);
      vectors++;
      if (bus.state !== q[i].st) begin
        miscompares++;
        $display("FAIL %s cyc%0d state: got %0d want %0d", name, i, bus.state, q[i].st);
      end
      vectors++;
      if (dut_o() !== q[i].o) begin
        miscompares++;
        $display("FAIL %s cyc%0d outputs: got %b want %b", name, i, dut_o(), q[i].o);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset mid-cycle, then release so the next edge enters FETCH
  task automatic reset_pulse(input string name);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.state !== RST) begin
      miscompares++;
      $display("FAIL %s async state: got %0d want %0d", name, bus.state, RST);
    end
    vectors++;
    if (dut_o() !== 17'd0) begin
      miscompares++;
      $display("FAIL %s async outputs: got %b want 0", name, dut_o());
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.opcode    = OP_RTYPE;
    bus.funct     = FN_ADD;
    bus.mem_ready = 1'b1;
    bus.alu_z     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.state !== RST) begin
      miscompares++;
      $display("FAIL reset state: got %0d want %0d", bus.state, RST);
    end
    vectors++;
    if (dut_o() !== 17'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got %b want 0", dut_o());
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    exec_instr("add", OP_RTYPE, FN_ADD, 0, 0, 0, -1, -1);
  endtask

  task automatic test_lw_wait();
    exec_instr("lw_wait3", OP_LW, 6'h11, 0, 3, 0, -1, -1);
    exec_instr("sw_wait2", OP_SW, 6'h05, 2, 2, 0, -1, -1);
  endtask

  task automatic test_branch();
    exec_instr("beq_z1", OP_BEQ, 6'h00, 0, 0, 0, 1, -1);
    exec_instr("bne_z1", OP_BNE, 6'h00, 0, 0, 0, 1, -1);
    exec_instr("bne_z0", OP_BNE, 6'h00, 1, 0, 0, 0, -1);
  endtask

  task automatic test_slt();
    exec_instr("slti", OP_SLTI, 6'h3C, 0, 0, 0, -1, -1);
    exec_instr("slt", OP_RTYPE, FN_SLT, 0, 0, 0, -1, -1);
    exec_instr("sub", OP_RTYPE, FN_SUB, 1, 0, 0, -1, -1);
  endtask

  task automatic test_trap();
    exec_instr("trap_op3f", 6'h3F, 6'h20, 0, 0, 20, -1, -1);
    reset_pulse("trap_op3f_rst");
    exec_instr("trap_fn00", OP_RTYPE, 6'h00, 1, 0, 20, -1, -1);
    reset_pulse("trap_fn00_rst");
  endtask

  task automatic test_reset_mem_wait();
    // fetch + decode + mem_addr + two MEM_WR wait cycles, then abort in the third
    exec_instr("sw_abort", OP_SW, 6'h00, 0, 6, 0, -1, 5);
    bus.mem_ready = 1'b0;
    vectors++;
    if (!(bus.state === MEM_WR && bus.mem_req === 1'b1 && bus.mem_wr === 1'b1)) begin
      miscompares++;
      $display("FAIL sw_abort pre: got state %0d req %b wr %b want %0d 1 1",
               bus.state, bus.mem_req, bus.mem_wr, MEM_WR);
    end
    reset_pulse("sw_abort_rst");
    exec_instr("after_abort", OP_ADDI, 6'h00, 0, 0, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    for (int k = 0; k < 60; k++) begin
      fn = 6'($urandom);
      case ($urandom_range(8))
        0: begin op = OP_RTYPE; fn = FN_ADD; end
        1: begin op = OP_RTYPE; fn = FN_SUB; end
        2: begin op = OP_RTYPE; fn = FN_SLT; end
        3: op = OP_ADDI;
        4: op = OP_SLTI;
        5: op = OP_LW;
        6: op = OP_SW;
        7: op = OP_BEQ;
        default: op = OP_BNE;
      endcase
      exec_instr($sformatf("rand%0d_op%02h", k, op), op, fn,
                 $urandom_range(3), $urandom_range(3), 0, -1, -1);
    end
    @(negedge clk);
    vectors++;
    if (bus.state !== FETCH) begin
      miscompares++;
      $display("FAIL final state: got %0d want %0d", bus.state, FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_slt();
    test_trap();
    test_reset_mem_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
